// File: rtl/muldiv_unit_if.sv
// ============================================================================
// muldiv_unit_if : request/response bundle for the RV32M multiply/divide unit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, opr_a, opr_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, opr_a, opr_b,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN selects a
//               single-cycle 33x33 multiplier for MUL/MULH/MULHSU/MULHU.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int                 c_cnt_w = $clog2(ITER);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(ITER - 1);
  localparam logic [XLEN-1:0]    c_min   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [XLEN-1:0]     r_mag_b;
  logic                r_neg_a;
  logic                r_neg_b;
  logic                r_spec;
  logic [XLEN-1:0]     r_spec_res;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_sign_a;
  logic                w_sign_b;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_spec;
  logic [XLEN-1:0]     w_spec_res;
  logic                w_skip;
  logic [XLEN:0]       w_add;
  logic [XLEN:0]       w_trial;
  logic [2*XLEN-1:0]   w_mul_step;
  logic [2*XLEN-1:0]   w_div_step;
  logic [2*XLEN-1:0]   w_prod;
  logic [2*XLEN-1:0]   w_prod_s;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fin_res;

  // A done pulse still marks the tail of the previous op, so start is held off.
  assign w_accept = (r_state == IDLE) && bus.start && !r_done;

  assign w_sign_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_sign_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign w_neg_a  = w_sign_a && bus.opr_a[XLEN-1];
  assign w_neg_b  = w_sign_b && bus.opr_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? (~bus.opr_a + 1'b1) : bus.opr_a;
  assign w_mag_b  = w_neg_b ? (~bus.opr_b + 1'b1) : bus.opr_b;

  assign w_div_zero = bus.funct3[2] && (bus.opr_b == '0);
  assign w_ovf      = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.opr_a == c_min) && (bus.opr_b == '1);
  assign w_spec     = w_div_zero || w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = bus.funct3[1] ? bus.opr_a : '1;
    end else if (w_ovf) begin
      w_spec_res = bus.funct3[1] ? '0 : c_min;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fast;

  assign w_skip = w_spec || !bus.funct3[2];
  assign w_fast = $signed({1'b0, r_acc[XLEN-1:0]}) * $signed({1'b0, r_mag_b});
  assign w_prod = r_op[2] ? r_acc : w_fast[2*XLEN-1:0];
`else
  assign w_skip = w_spec;
  assign w_prod = r_acc;
`endif

  // Shift-add: conditionally add multiplicand into the upper half, shift right.
  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_mag_b} : {(XLEN+1){1'b0}});
  assign w_mul_step = {w_add, r_acc[XLEN-1:1]};

  // Restoring divide: upper half is the remainder, quotient bits enter at LSB.
  assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mag_b};
  assign w_div_step = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod_s = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_acc[XLEN-1:0];
  assign w_rem    = r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fin_res = '0;
    if (r_spec) begin
      w_fin_res = r_spec_res;
    end else if (r_op[2]) begin
      if (r_op[1]) begin
        w_fin_res = r_neg_a ? (~w_rem + 1'b1) : w_rem;
      end else begin
        w_fin_res = (r_neg_a ^ r_neg_b) ? (~w_quo + 1'b1) : w_quo;
      end
    end else if (r_op[1:0] == 2'b00) begin
      w_fin_res = w_prod_s[XLEN-1:0];
    end else begin
      w_fin_res = w_prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_skip ? FIN : CALC;
      CALC: if (r_cnt == c_last) w_next = FIN;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_cnt      <= '0;
      r_mag_b    <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_acc      <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= bus.funct3;
            r_cnt      <= '0;
            r_mag_b    <= w_mag_b;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_acc      <= {{XLEN{1'b0}}, w_mag_a};
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 1'b1;
        end
        FIN: begin
          r_result <= w_fin_res;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed scoreboard bench for muldiv_unit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          icyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops and checks one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_done: got done=1 result=%h, want no pulse", bus.result);
        end else begin
          e = sb.pop_front();
          chk32({e.name, " result"}, bus.result, e.res);
          chk_int({e.name, " latency"}, cyc - e.icyc + 1, e.lat);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while (!(bus.busy === 1'b0 && bus.done === 1'b0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL %s idle_timeout: got busy=%b, want 0", nm, bus.busy);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input bit keep);
    exp_t e;
    wait_idle(nm);
    bus.funct3 = f;
    bus.opr_a  = a;
    bus.opr_b  = b;
    bus.start  = 1'b1;
    @(negedge clk);
    chk32({nm, " busy"}, {31'b0, bus.busy}, 32'd1);
    e.res  = res;
    e.lat  = lat;
    e.icyc = cyc;
    e.name = nm;
    sb.push_back(e);
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.opr_a  = '0;
    bus.opr_b  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk32("reset busy",   {31'b0, bus.busy}, 32'd0);
    chk32("reset done",   {31'b0, bus.done}, 32'd0);
    chk32("reset result", bus.result, 32'd0);
    rst = 1'b0;

    issue("MUL_m1xm1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT, 0);
    issue("MULH_m1xm1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, 0);
    issue("MULHU_m1xm1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0);
    issue("MULHSU_m1x2",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT, 0);
    issue("MUL_low",      3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT, 0);
    issue("MULHU_2p33",   3'b011, 32'h80000000, 32'h00000004, 32'h00000002, MUL_LAT, 0);
    issue("MULH_min_sq",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
    issue("DIV_m7_2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT, 0);
    issue("REM_m7_2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT, 0);
    issue("REMU_7_2",     3'b111, 32'h00000007, 32'h00000002, 32'h00000001, DIV_LAT, 0);
    issue("DIV_7_m2",     3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, 0);
    issue("REM_7_m2",     3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT, 0);
    issue("DIVU_max_1",   3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, DIV_LAT, 0);
    issue("DIV_5_0",      3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC_LAT, 0);
    issue("REMU_5_0",     3'b111, 32'h00000005, 32'h00000000, 32'h00000005, SPC_LAT, 0);
    issue("REM_m5_0",     3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, SPC_LAT, 0);
    issue("DIVU_5_0",     3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC_LAT, 0);
    issue("DIV_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT, 0);
    issue("REM_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT, 0);
    issue("DIVU_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT, 0);

    // Reset during CALC: no done afterwards, everything back to zero.
    issue("DIVU_abort",   3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk32("midrst busy",   {31'b0, bus.busy}, 32'd0);
    chk32("midrst done",   {31'b0, bus.done}, 32'd0);
    chk32("midrst result", bus.result, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk32("post_rst busy", {31'b0, bus.busy}, 32'd0);
    issue("DIVU_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);

    // Start pulsed while busy must be ignored.
    issue("DIVU_busy_ign", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);
    repeat (4) @(negedge clk);
    bus.funct3 = 3'b000;
    bus.opr_a  = 32'd3;
    bus.opr_b  = 32'd3;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;

    // Start held through done: next op accepted one cycle after done.
    issue("DIVU_held", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1);
    t = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL held done_timeout: got done=%b, want 1", bus.done);
    end
    bus.funct3 = 3'b111;
    bus.opr_a  = 32'd100;
    bus.opr_b  = 32'd7;
    @(negedge clk);
    chk32("held gap busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk32("held second busy", {31'b0, bus.busy}, 32'd1);
    e.res  = 32'd2;
    e.lat  = DIV_LAT;
    e.icyc = cyc;
    e.name = "REMU_held";
    sb.push_back(e);
    bus.start = 1'b0;

    t = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
